// File: rtl/out_commit_sched.sv
// Output commit scheduler: synchronises and debounces 36 interlock requests, drops
// turn-offs at once and releases turn-ons one channel at a time with a settle gap.
module out_commit_sched #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned GAP_CYCLES = 50
) (
    input  logic        pclk_50M,
    input  logic        rst,
    input  logic        en,
    input  logic [1:8]  outP,
    input  logic [1:28] out,
    output logic [1:8]  eoutP,
    output logic [1:28] eout,
    output logic        busy,
    output logic [5:0]  last_on
);

    localparam int unsigned NCH = 36;
    localparam int unsigned CW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [0:0] {StIdle, StGap} state_e;

    state_e          state;
    logic [GW-1:0]   gcnt;
    logic [NCH-1:0]  req;
    logic [NCH-1:0]  sync1;
    logic [NCH-1:0]  s;
    logic [NCH-1:0]  filt;
    logic [NCH-1:0]  commit;
    logic [CW-1:0]   cnt [NCH];
    logic [NCH-1:0]  off_mask;
    logic [NCH-1:0]  on_mask;
    logic [NCH-1:0]  on_pick;
    logic [5:0]      on_idx;

    // Flatten to channel index order: power outputs first, then signal outputs.
    for (genvar g = 0; g < 8; g++) begin : g_pwr
        assign req[g]    = outP[g+1];
        assign eoutP[g+1] = commit[g];
    end
    for (genvar g = 0; g < 28; g++) begin : g_sig
        assign req[8+g]  = out[g+1];
        assign eout[g+1] = commit[8+g];
    end

    always_ff @(posedge pclk_50M) begin
        if (rst) begin
            sync1 <= '0;
            s     <= '0;
            filt  <= '0;
            for (int i = 0; i < int'(NCH); i++) cnt[i] <= '0;
        end else begin
            sync1 <= req;
            s     <= sync1;
            for (int i = 0; i < int'(NCH); i++) begin
                if (s[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    filt[i] <= s[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign off_mask = commit & ~filt;
    assign on_mask  = filt & ~commit & {NCH{en}};
    assign busy     = (state == StGap) | (|on_mask);

    // Scan downwards so the lowest requesting index wins.
    always_comb begin
        on_pick = '0;
        on_idx  = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (on_mask[i]) begin
                on_pick    = '0;
                on_pick[i] = 1'b1;
                on_idx     = 6'(i);
            end
        end
    end

    always_ff @(posedge pclk_50M) begin
        if (rst) begin
            state   <= StIdle;
            gcnt    <= '0;
            commit  <= '0;
            last_on <= '0;
        end else if (!en) begin
            state  <= StIdle;
            gcnt   <= '0;
            commit <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    commit <= (commit & ~off_mask) | on_pick;
                    if (|on_mask) begin
                        last_on <= on_idx;
                        gcnt    <= GW'(GAP_CYCLES - 1);
                        state   <= StGap;
                    end
                end
                StGap: begin
                    commit <= commit & ~off_mask;
                    if (gcnt == '0) state <= StIdle;
                    else            gcnt  <= gcnt - 1'b1;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_out_commit_sched.sv
// Bench for out_commit_sched: random and directed request patterns checked every cycle
// against a history-window model of debounce and a timestamp model of the turn-on gap.
module tb_out_commit_sched;

    localparam int DEB  = 4;
    localparam int GAP  = 50;
    localparam int NONE = -1000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:8]  outP;
    logic [1:28] out;
    logic [1:8]  eoutP;
    logic [1:28] eout;
    logic        busy;
    logic [5:0]  last_on;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: committed vector, accepted requests, input and sync histories.
    logic [35:0] m_commit;
    logic [35:0] m_filt;
    logic [5:0]  m_last_on;
    logic [35:0] in_hist [2];
    logic [35:0] s_hist [DEB];
    int          edge_no = 0;
    int          t_on = NONE;
    bit          m_valid = 1'b0;

    always #10 clk = ~clk;

    out_commit_sched #(
        .DEB_CYCLES (DEB),
        .GAP_CYCLES (GAP)
    ) dut (
        .pclk_50M (clk),
        .rst      (rst),
        .en       (en),
        .outP     (outP),
        .out      (out),
        .eoutP    (eoutP),
        .eout     (eout),
        .busy     (busy),
        .last_on  (last_on)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_no, got, exp);
        end
    endtask

    function automatic logic [35:0] req_vec(input logic [1:8] p, input logic [1:28] o);
        logic [35:0] v;
        for (int i = 0; i < 8; i++) v[i] = p[i+1];
        for (int j = 0; j < 28; j++) v[8+j] = o[j+1];
        return v;
    endfunction

    task automatic set_req(input logic [35:0] v);
        for (int i = 0; i < 8; i++) outP[i+1] = v[i];
        for (int j = 0; j < 28; j++) out[j+1] = v[8+j];
    endtask

    // One clock edge of reference behaviour, from the values present at that edge.
    task automatic model_step();
        logic [35:0] cur, s_now, flip, off_m, on_m;
        bit found;
        cur = req_vec(outP, out);
        edge_no++;
        if (rst) begin
            m_commit  = '0;
            m_filt    = '0;
            m_last_on = '0;
            in_hist[0] = '0;
            in_hist[1] = '0;
            for (int k = 0; k < DEB; k++) s_hist[k] = '0;
            t_on    = NONE;
            m_valid = 1'b1;
        end else begin
            s_now = in_hist[1];
            for (int k = DEB - 1; k > 0; k--) s_hist[k] = s_hist[k-1];
            s_hist[0] = s_now;
            // A bit is accepted once its last DEB synchronised samples all disagree with it.
            flip = '1;
            for (int k = 0; k < DEB; k++) flip &= (s_hist[k] ^ m_filt);
            off_m = m_commit & ~m_filt;
            on_m  = m_filt & ~m_commit & {36{en}};
            if (!en) begin
                m_commit = '0;
                t_on     = NONE;
            end else begin
                m_commit &= ~off_m;
                if (!((edge_no - 1 - t_on) < GAP)) begin
                    found = 1'b0;
                    for (int i = 0; i < 36; i++) begin
                        if (!found && on_m[i]) begin
                            found       = 1'b1;
                            m_commit[i] = 1'b1;
                            m_last_on   = 6'(i);
                            t_on        = edge_no;
                        end
                    end
                end
            end
            m_filt ^= flip;
            in_hist[1] = in_hist[0];
            in_hist[0] = cur;
        end
    endtask

    task automatic compare();
        logic exp_busy;
        exp_busy = ((edge_no - t_on) < GAP) || ((m_filt & ~m_commit & {36{en}}) != '0);
        check_eq("commit", 64'(req_vec(eoutP, eout)), 64'(m_commit));
        check_eq("busy", 64'(busy), 64'(exp_busy));
        check_eq("last_on", 64'(last_on), 64'(m_last_on));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (m_valid) compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        logic [35:0] v;
        logic [35:0] flips;
        rst = 1'b1;
        en  = 1'b1;
        set_req('1);
        run(3);
        check_eq("rst_eoutP", 64'(eoutP), 64'd0);
        check_eq("rst_eout", 64'(eout), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        run(6);
        check_eq("first_on_early", 64'(eoutP), 64'd0);
        run(1);
        check_eq("first_on", 64'(eoutP), 64'h80);
        run(300);

        // Glitch rejection on out[16], then a pulse just long enough to pass.
        set_req('0);
        run(80);
        out[16] = 1'b1;
        run(1);
        out[16] = 1'b0;
        run(20);
        check_eq("glitch_eout16", 64'(eout[16]), 64'd0);
        check_eq("glitch_busy", 64'(busy), 64'd0);
        out[16] = 1'b1;
        run(4);
        out[16] = 1'b0;
        run(2);
        check_eq("pulse4_early", 64'(eout[16]), 64'd0);
        run(1);
        check_eq("pulse4_rise", 64'(eout[16]), 64'd1);
        run(80);

        // Power burst 11110101 sequenced in index order.
        outP = 8'b11110101;
        run(7 + 5 * (GAP + 1));
        check_eq("seq_last_on", 64'(last_on), 64'd7);
        check_eq("seq_eoutP", 64'(eoutP), 64'b11110101);
        run(GAP - 1);
        check_eq("seq_busy_tail", 64'(busy), 64'd1);
        run(1);
        check_eq("seq_busy_end", 64'(busy), 64'd0);

        // Turn-off during a gap while more turn-ons are pending.
        outP = '1;
        out  = '1;
        run(400);
        outP[1] = 1'b0;
        for (int j = 1; j <= 8; j++) out[j] = 1'b0;
        run(120);

        // Enable drop mid-gap, then restart.
        run(20);
        en = 1'b0;
        run(1);
        check_eq("en_drop_eoutP", 64'(eoutP), 64'd0);
        check_eq("en_drop_eout", 64'(eout), 64'd0);
        run(30);
        en = 1'b1;
        run(200);

        // Reset in the middle of a gap.
        run(29);
        rst = 1'b1;
        run(1);
        check_eq("rst_mid_eout", 64'(eout), 64'd0);
        rst = 1'b0;
        run(200);

        // Random request patterns with sparse flips, glitches, enable drops and resets.
        for (int it = 0; it < 160; it++) begin
            v     = req_vec(outP, out);
            flips = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) begin
                set_req(v ^ flips);
                run($urandom_range(1, 5));
                set_req(v);
            end else begin
                set_req(v ^ flips);
            end
            if ($urandom_range(0, 19) == 0) begin
                en = 1'b0;
                run($urandom_range(1, 10));
                en = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                run($urandom_range(1, 3));
                rst = 1'b0;
            end
            run($urandom_range(1, 120));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
